// File: rtl/handshake_pkg.sv
// Shared types and default constants for the three-channel round-robin merge
// in front of the foo_RTL handshake consumer.
package handshake_pkg;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_N     = 3;
  localparam int DEF_SRC_W = $clog2(DEF_N);

  // One output FIFO slot: originating channel plus its payload.
  typedef struct packed {
    logic [DEF_SRC_W-1:0] src;
    logic [DEF_WIDTH-1:0] data;
  } rr_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: the search starts at ptr and wraps modulo N;
// the first requester found wins. Purely combinational.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx,
  output logic          any_req
);

  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any_req && req[c]) begin
        any_req  = 1'b1;
        grant[c] = 1'b1;
        idx      = c[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/handshake_rr_merge.sv
// Merges N ready/valid producer channels into one stream through a small
// output FIFO; each entry carries the channel index it came from.
module handshake_rr_merge
  import handshake_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 2,
  parameter int N     = DEF_N,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         arr_valid,
  output logic [N-1:0]         arr_ready,
  input  logic [N*WIDTH-1:0]   arr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(N)-1:0] out_src,
  output logic [CNT_W-1:0]     xfer_count
);

  localparam int SW = $clog2(N);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SW-1:0]    src;
    logic [WIDTH-1:0] data;
  } entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  entry_t         head_q, head_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  prio_q, prio_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]     grant;
  logic [SW-1:0]    win_idx;
  logic             any_req;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] win_data;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req     (arr_valid),
    .ptr     (prio_q),
    .grant   (grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  // Full is judged on registered count only: a pop in the same cycle does
  // not free a slot for a push.
  assign full      = (cnt_q == CW'(DEPTH));
  assign push      = any_req & ~full & ASYNCRESETN;
  assign pop       = out_valid_q & out_ready;
  assign arr_ready = push ? grant : '0;
  assign win_data  = arr_data[int'(win_idx)*WIDTH +: WIDTH];

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    xfer_d      = xfer_q;
    head_d      = head_q;
    out_valid_d = out_valid_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{src: win_idx, data: win_data};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      prio_d          = (win_idx == SW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      xfer_d   = xfer_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // The head register keeps its last value when the FIFO drains, so the
    // data lines never go X and stay quiet while empty.
    out_valid_d = (cnt_d != '0);
    if (cnt_d != '0) head_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      prio_q      <= '0;
      xfer_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      xfer_q      <= xfer_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = head_q.data;
  assign out_src    = head_q.src;
  assign xfer_count = xfer_q;

endmodule

// File: doc/handshake_rr_merge.md
Name: handshake_rr_merge

Overview:
- Upstream neighbour of foo_RTL_unq1: merges three ready/valid producer channels into the single handshake stream that foo_RTL consumes.
- Round-robin arbitration selects one channel per cycle. The winning payload goes into a small output FIFO.
- The FIFO head drives the downstream valid/data. The source channel index travels with each payload so the consumer and its bound monitor can attribute every transfer.

Parameters:
- WIDTH, 5: payload bits per channel, matching the in1/in2 width.
- DEPTH, 2: output FIFO entries; must be ≥1.
- N, 3: number of upstream channels, matching handshake_arr length; must be ≥2.
- CNT_W, 16: width of the transfer counter.

Ports:
- CLK, input, 1: the single clock, rising edge.
- ASYNCRESETN, input, 1: reset, asynchronous assert, active-low.
- arr_valid, input, N: per-channel valid.
- arr_ready, output, N: per-channel ready.
- arr_data, input, N*WIDTH: per-channel payload. Channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid, output, 1: downstream valid (feeds handshake_valid).
- out_ready, input, 1: downstream ready (from handshake_ready).
- out_data, output, WIDTH: head payload (feeds in1).
- out_src, output, clog2(N): head source channel index.
- xfer_count, output, CNT_W: number of completed downstream transfers.

Behaviour:
- Reset: asynchronous on ASYNCRESETN low; state is cleared immediately and held while low. Reset values:
  - FIFO count = 0, read/write pointers = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - priority pointer = 0, so channel 0 is most favoured.
  - xfer_count = 0.
  - arr_ready = 0 for all channels while reset is asserted.
- Reset release is synchronous to CLK. The first accept is possible on the first rising edge after deassertion.
- Arbitration (combinational):
  - Search channels starting at the priority pointer, wrapping modulo N. The first channel with arr_valid set wins.
  - At most one arr_ready bit is high per cycle.
  - arr_ready[i] = (i == winner) & any_valid & !full, where full = (count == DEPTH), taken from registered state only.
  - No pop-to-push pass-through when full: a full FIFO blocks the push even if a pop happens in the same cycle.
  - arr_ready may depend combinationally on other channels' arr_valid. Producers must not make arr_valid depend on arr_ready.
- Priority update:
  - Updates only on an accepted upstream transfer; the pointer becomes (winner+1) mod N.
  - If nothing is accepted, the pointer holds.
  - With all channels continuously valid, the grant sequence is 0,1,2,0,...
- Push: on arr_valid[w] & arr_ready[w], write {w, arr_data[w]} at the write pointer and increment the write pointer modulo DEPTH.
- Pop: on out_valid & out_ready, increment the read pointer modulo DEPTH and increment xfer_count.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Simultaneous push and pop is legal whenever count is between 1 and DEPTH-1.
- Output side:
  - out_valid = (count != 0), registered.
  - out_data and out_src reflect the FIFO head.
  - Accept-to-out_valid latency is 1 cycle.
- Empty FIFO: out_valid = 0. out_data/out_src hold the last head value and are don't-care, but must not be X after reset.
- Stall: while out_valid & !out_ready, out_data and out_src remain stable cycle to cycle. This is the AXI-style rule asserted by the foo_RTL monitor.
- Ordering: FIFO order is strictly the accept order; there is no reordering.
- xfer_count: wraps from 2^CNT_W-1 to 0 without saturating.
- Mid-operation reset: in-flight FIFO contents are discarded. There is no requirement to drain.

Decomposition:
- Shared package handshake_pkg holds:
  - the typedef for the FIFO entry {src index, payload};
  - the default constants WIDTH=5, N=3;
  - a clog2-based SRC_W constant.
- Sub-module rr_arbiter (N-way, pointer input, one-hot grant plus index output) is natural and reused elsewhere.
- The FIFO stays inline in the top module.

Test Plan:
- Reset then idle: hold ASYNCRESETN low for 3 cycles, then release with no arr_valid.
  - Required: out_valid=0, arr_ready=000, xfer_count=0. Asserting reset mid-cycle clears out_valid without waiting for a CLK edge.
- Single channel: arr_valid=010, data 5'h15, out_ready=1.
  - Required: arr_ready=010 in the same cycle; next cycle out_valid=1, out_data=5'h15, out_src=1; xfer_count=1 after the pop.
- Fairness: all three channels valid continuously with data 5'h01/5'h02/5'h03, out_ready=1.
  - Required: out_src sequence 0,1,2,0,1,2 with matching data; xfer_count=6 after 6 pops.
- Backpressure: out_ready=0, all channels valid.
  - Required: exactly DEPTH=2 accepts (channel 0, then channel 1), then arr_ready=000.
  - out_data stays 5'h01 while stalled.
  - Raising out_ready for 1 cycle pops one entry; channel 2 is accepted on the following cycle, not in the pop cycle.
- Simultaneous push/pop at count=1: entry from channel 0 is held; present channel 1 valid with out_ready=1.
  - Required: count stays 1; out_data switches to channel 1's payload the next cycle.
- Counter wrap: force xfer_count to 16'hFFFF via a long run, or run with CNT_W=4 for 17 transfers.
  - Required: the count wraps to 0 and then reaches 1.
